// File: rtl/cam_power_sequencer_pkg.sv
// Shared types and default timing for the camera power-up sequencer.
// Pairs with cam_power_sequencer; the optional lock-wait timeout is enabled by LOCK_TIMEOUT_EN.
package cam_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_XCLK_ON   = 3'd2,
    ST_PWDN_LOW  = 3'd3,
    ST_RST_REL   = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } cam_seq_state_t;

  localparam int unsigned LOCK_STABLE_CYC_DEF = 1024;
  localparam int unsigned XCLK_PRE_CYC_DEF    = 256;
  localparam int unsigned RST_HOLD_CYC_DEF    = 27000;
  localparam int unsigned SETTLE_CYC_DEF      = 540000;
  localparam int unsigned MAX_RETRY_DEF       = 3;
  localparam int unsigned TIMEOUT_CYC_DEF     = 2700000;
  localparam int unsigned RETRY_W             = 2;

  function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d,
                                       input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/cam_power_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cam_power_sequencer.sv
// Camera sensor power-up sequencer driven by the camera PLL lock.
// Define LOCK_TIMEOUT_EN to abort a lock wait that exceeds TIMEOUT_CYC cycles.
module cam_power_sequencer
  import cam_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int unsigned XCLK_PRE_CYC    = XCLK_PRE_CYC_DEF,
  parameter int unsigned RST_HOLD_CYC    = RST_HOLD_CYC_DEF,
  parameter int unsigned SETTLE_CYC      = SETTLE_CYC_DEF,
  parameter int unsigned MAX_RETRY       = MAX_RETRY_DEF,
  parameter int unsigned TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W           = $clog2(max5(LOCK_STABLE_CYC, XCLK_PRE_CYC,
                                                       RST_HOLD_CYC, SETTLE_CYC,
                                                       TIMEOUT_CYC)) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               pll_lock_i,
  output logic               cam_xclk_en_o,
  output logic               cam_pwdn_o,
  output logic               cam_rst_n_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   XCLK_LOAD   = CNT_W'(XCLK_PRE_CYC - 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
`ifdef LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   WAIT_LOAD   = CNT_W'(TIMEOUT_CYC - 1);
`else
  localparam logic [CNT_W-1:0]   WAIT_LOAD   = '0;
`endif

  cam_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_s;
  logic               xclk_d, pwdn_d, rst_n_d, ready_d, fault_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;

    if (!en_i) begin
      state_d = ST_OFF;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_WAIT_LOCK;
          stable_d = '0;
          timer_d  = WAIT_LOAD;
        end
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            stable_d = '0;
          end else if (stable_q == STABLE_LAST) begin
            state_d = ST_XCLK_ON;
            timer_d = XCLK_LOAD;
          end else begin
            stable_d = stable_q + 1'b1;
          end
`ifdef LOCK_TIMEOUT_EN
          // The shared timer is otherwise idle here, so it doubles as the lock-wait timeout.
          if (state_d == ST_WAIT_LOCK) begin
            if (timer_q == '0) state_d = ST_FAULT;
            else               timer_d = timer_q - 1'b1;
          end
`endif
        end
        ST_XCLK_ON, ST_PWDN_LOW, ST_RST_REL, ST_READY: begin
          if (!lock_s) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d  = ST_WAIT_LOCK;
              stable_d = '0;
              timer_d  = WAIT_LOAD;
              if (retry_q != '1) retry_d = retry_q + 1'b1;
            end
          end else if (state_q != ST_READY) begin
            if (timer_q != '0) begin
              timer_d = timer_q - 1'b1;
            end else begin
              case (state_q)
                ST_XCLK_ON: begin
                  state_d = ST_PWDN_LOW;
                  timer_d = HOLD_LOAD;
                end
                ST_PWDN_LOW: begin
                  state_d = ST_RST_REL;
                  timer_d = SETTLE_LOAD;
                end
                default: state_d = ST_READY;
              endcase
            end
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_OFF;
      endcase
    end

    xclk_d  = state_d inside {ST_XCLK_ON, ST_PWDN_LOW, ST_RST_REL, ST_READY};
    pwdn_d  = !(state_d inside {ST_PWDN_LOW, ST_RST_REL, ST_READY});
    rst_n_d = state_d inside {ST_RST_REL, ST_READY};
    ready_d = (state_d == ST_READY);
    fault_d = (state_d == ST_FAULT);
  end

  // Pin outputs are flopped from the next state so they change on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      timer_q       <= '0;
      stable_q      <= '0;
      retry_q       <= '0;
      cam_xclk_en_o <= 1'b0;
      cam_pwdn_o    <= 1'b1;
      cam_rst_n_o   <= 1'b0;
      ready_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stable_q      <= stable_d;
      retry_q       <= retry_d;
      cam_xclk_en_o <= xclk_d;
      cam_pwdn_o    <= pwdn_d;
      cam_rst_n_o   <= rst_n_d;
      ready_o       <= ready_d;
      fault_o       <= fault_d;
    end
  end

  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_cam_power_sequencer.sv
// Self-checking bench for cam_power_sequencer: directed vector table, hand corner cases,
// and randomized traffic against a phase/elapsed-time reference model.
module tb_cam_power_sequencer;

  localparam int LS = 4;
  localparam int XP = 3;
  localparam int RH = 5;
  localparam int SC = 6;
  localparam int MR = 2;
  localparam int TO = 50;

  localparam int P_OFF   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_XCLK  = 2;
  localparam int P_PWDN  = 3;
  localparam int P_REL   = 4;
  localparam int P_READY = 5;
  localparam int P_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic       pll_lock_i;
  logic       cam_xclk_en_o;
  logic       cam_pwdn_o;
  logic       cam_rst_n_o;
  logic       ready_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_power_sequencer #(
    .LOCK_STABLE_CYC (LS),
    .XCLK_PRE_CYC    (XP),
    .RST_HOLD_CYC    (RH),
    .SETTLE_CYC      (SC),
    .MAX_RETRY       (MR),
    .TIMEOUT_CYC     (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .pll_lock_i    (pll_lock_i),
    .cam_xclk_en_o (cam_xclk_en_o),
    .cam_pwdn_o    (cam_pwdn_o),
    .cam_rst_n_o   (cam_rst_n_o),
    .ready_o       (ready_o),
    .fault_o       (fault_o),
    .retry_cnt_o   (retry_cnt_o)
  );

  // Reference model: phase index plus elapsed cycles in that phase.
  int m_phase, m_run, m_elapsed, m_wait_cyc, m_retry;
  bit m_s1, m_s2;

  function automatic int phase_len(input int p);
    case (p)
      P_XCLK:  return XP;
      P_PWDN:  return RH;
      default: return SC;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_OFF; m_run = 0; m_elapsed = 0; m_wait_cyc = 0; m_retry = 0;
    m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_s2;
    if (rst) begin
      model_reset();
      return;
    end
    m_s2 = m_s1;
    m_s1 = pll_lock_i;
    if (!en_i) begin
      m_phase = P_OFF;
      m_retry = 0;
      return;
    end
    case (m_phase)
      P_OFF: begin
        m_phase = P_WAIT; m_run = 0; m_wait_cyc = 0;
      end
      P_WAIT: begin
        m_run = ls ? m_run + 1 : 0;
        m_wait_cyc++;
        if (m_run == LS) begin
          m_phase = P_XCLK; m_elapsed = 0;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (m_wait_cyc == TO) m_phase = P_FAULT;
`endif
      end
      P_FAULT: ;
      default: begin
        if (!ls) begin
          if (m_retry == MR) m_phase = P_FAULT;
          else begin
            m_retry = (m_retry < 3) ? m_retry + 1 : 3;
            m_phase = P_WAIT; m_run = 0; m_wait_cyc = 0;
          end
        end else if (m_phase != P_READY) begin
          m_elapsed++;
          if (m_elapsed == phase_len(m_phase)) begin
            m_phase = m_phase + 1; m_elapsed = 0;
          end
        end
      end
    endcase
  endtask

  function automatic logic [6:0] model_out();
    logic x, p, r, rd, f;
    x  = (m_phase >= P_XCLK && m_phase <= P_READY);
    p  = !(m_phase >= P_PWDN && m_phase <= P_READY);
    r  = (m_phase == P_REL || m_phase == P_READY);
    rd = (m_phase == P_READY);
    f  = (m_phase == P_FAULT);
    return {x, p, r, rd, f, 2'(m_retry)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {cam_xclk_en_o, cam_pwdn_o, cam_rst_n_o, ready_o, fault_o, retry_cnt_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (xclk,pwdn,rst_n,ready,fault,retry[1:0])", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit         lock;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit e, input bit l, input int n,
                              input logic [6:0] exp);
    vec_t v;
    v.rst = r; v.en = e; v.lock = l; v.n = n; v.exp = exp;
    return v;
  endfunction

  initial begin
    int n;
    bit seen;
    int hold;
    rst = 1'b1; en_i = 1'b0; pll_lock_i = 1'b0;
    model_reset();

    // {xclk, pwdn, rst_n, ready, fault, retry}
    tbl.push_back(mk(1, 0, 0,  2, 7'b0100000));
    tbl.push_back(mk(0, 1, 1,  5, 7'b0100000));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1100000));
    tbl.push_back(mk(0, 1, 1,  2, 7'b1100000));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1000000));
    tbl.push_back(mk(0, 1, 1,  4, 7'b1000000));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1010000));
    tbl.push_back(mk(0, 1, 1,  5, 7'b1010000));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1011000));
    tbl.push_back(mk(0, 1, 1, 10, 7'b1011000));
    tbl.push_back(mk(0, 1, 0,  2, 7'b1011000));
    tbl.push_back(mk(0, 1, 0,  1, 7'b0100001));
    tbl.push_back(mk(0, 1, 1,  5, 7'b0100001));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1100001));
    tbl.push_back(mk(0, 1, 1, 13, 7'b1010001));
    tbl.push_back(mk(0, 1, 1,  1, 7'b1011001));
    tbl.push_back(mk(0, 1, 0,  3, 7'b0100010));
    tbl.push_back(mk(0, 1, 1,  6, 7'b1100010));
    tbl.push_back(mk(0, 1, 1, 14, 7'b1011010));
    tbl.push_back(mk(0, 1, 0,  3, 7'b0100110));
    tbl.push_back(mk(0, 1, 0,  5, 7'b0100110));
    tbl.push_back(mk(0, 1, 1, 20, 7'b0100110));
    tbl.push_back(mk(0, 0, 1,  1, 7'b0100000));
    tbl.push_back(mk(0, 1, 1, 10, 7'b1000000));
    tbl.push_back(mk(0, 0, 1,  1, 7'b0100000));
    tbl.push_back(mk(0, 1, 1, 10, 7'b1000000));

    foreach (tbl[r]) begin
      rst = tbl[r].rst; en_i = tbl[r].en; pll_lock_i = tbl[r].lock;
      for (int c = 0; c < tbl[r].n; c++) tick();
      check($sformatf("vec%0d", r), 32'(dut_out()), 32'(tbl[r].exp));
    end

    // Async reset while in PWDN_LOW: outputs return before the next clock edge.
    #1 rst = 1'b1;
    #1 check("async_rst", 32'(dut_out()), 32'(7'b0100000));
    tick();

    // Lock glitch: 3 high, 1 low, then steady -> xclk_en only after a full fresh run.
    rst = 1'b0; en_i = 1'b1; pll_lock_i = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    for (int k = 1; k <= 10; k++) begin
      pll_lock_i = (k != 4);
      tick();
      check($sformatf("glitch_k%0d", k), 32'(dut_out()),
            32'({(k >= 10) ? 1'b1 : 1'b0, 6'b100000}));
    end

    en_i = 1'b0; tick();
    en_i = 1'b1; pll_lock_i = 1'b0;
`ifdef LOCK_TIMEOUT_EN
    n = 0;
    while (!fault_o && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO + 1));
`else
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (fault_o) seen = 1;
    end
    check("no_timeout", 32'(seen), 32'(0));
`endif

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      en_i = ($urandom_range(0, 79) != 0);
      if (hold == 0) begin
        pll_lock_i = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      tick();
      check($sformatf("rand%0d", c), 32'(dut_out()), 32'(model_out()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
